// File: rtl/my_serial_addsub.sv
// my_serial_addsub: multi-cycle add/subtract built from one DIGIT-bit adder
// slice reused over N = WIDTH/DIGIT cycles, least-significant digit first.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request an operation; taken only when busy=0
//   sub, cin, a, b    mode (0 add / 1 a-b), carry/borrow-in and operands, sampled with start
//   busy              high for exactly the N digit cycles
//   done              one-cycle pulse; r/cout/ovf valid
//   r, cout, ovf      result, carry-out (sub: 1 = no borrow), signed overflow; held until next done

// One digit of the ripple: sum, carry-out, and the carry into the digit's top bit.
module my_serial_addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [DIGIT:0] t;
  assign t  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign s  = t[DIGIT-1:0];
  assign co = t[DIGIT];
  // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out by xor
  assign cm = t[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

module my_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] areg, breg, sreg, res_nx, dext;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [DIGIT-1:0] dsum;
  logic             dco, dcm;

  my_serial_addsub_digit #(.DIGIT(DIGIT)) u_dig (
    .a  (areg[DIGIT-1:0]),
    .b  (breg[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco),
    .cm (dcm)
  );

  assign busy   = (state == RUN);
  assign done   = (state == FIN);
  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  // New digit enters the result from the top; written as shifts so DIGIT==WIDTH stays legal.
  assign dext   = WIDTH'(dsum);
  assign res_nx = (sreg >> DIGIT) | (dext << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      r     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // subtract as a + ~b + ~borrow
      areg  <= a;
      breg  <= sub ? ~b : b;
      carry <= sub ^ cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      areg  <= areg >> DIGIT;
      breg  <= breg >> DIGIT;
      sreg  <= res_nx;
      carry <= dco;
      cnt   <= cnt + 1'b1;
      // outputs move only as a whole, on the edge into FIN
      if (last) begin
        r    <= res_nx;
        cout <= dco;
        ovf  <= dcm ^ dco;
      end
    end
  end
endmodule

// File: tb/tb_my_serial_addsub.sv
module tb_my_serial_addsub;
  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, sub = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] r;

  logic start4 = 0;
  logic [W-1:0] a4 = '0, b4 = '0;
  logic busy4, done4, cout4, ovf4;
  logic [W-1:0] r4;

  always #5 clk = ~clk;

  my_serial_addsub #(.WIDTH(W), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .cout(cout), .ovf(ovf));

  my_serial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(1'b0), .cin(1'b0), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .r(r4), .cout(cout4), .ovf(ovf4));

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] r;
    logic         cout, ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         cout, ovf;
    int           due;
  } exp_t;

  exp_t q[$];
  int n_pass = 0, n_chk = 0;
  int cyc = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // independent reference: plain wide addition, overflow from operand/result signs
  function automatic exp_t model(logic [W-1:0] ia, logic [W-1:0] ib, logic isub, logic icin);
    exp_t e;
    logic [W-1:0] be;
    logic [W:0]   s;
    be = isub ? ~ib : ib;
    s = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, isub ^ icin};
    e.r = s[W-1:0];
    e.cout = s[W];
    e.ovf = (ia[W-1] == be[W-1]) && (s[W-1] != ia[W-1]);
    e.due = 0;
    return e;
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("r", 32'(r), 32'(e.r));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge with busy=0: the next edge accepts these operands.
  task automatic issue(logic [W-1:0] ia, logic [W-1:0] ib, logic isub, logic icin,
                       logic [W-1:0] er, logic ec, logic eo);
    exp_t e;
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    e.r = er; e.cout = ec; e.ovf = eo; e.due = cyc + 1 + N;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_not_busy();
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    tbl[2] = '{16'hFFFF, 16'h0001, 0, 1, 16'h0001, 1, 0};
    tbl[3] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    tbl[4] = '{16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1};
    tbl[5] = '{16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0};
    tbl[6] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFD, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    // table vectors, issued back-to-back (next start lands in the FIN cycle)
    for (int i = 0; i < 7; i++) begin
      wait_not_busy();
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].r, tbl[i].cout, tbl[i].ovf);
    end
    drain();

    // random vectors against the reference model, operands scrambled mid-run
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc;
      exp_t e;
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      e = model(ra, rb, rs, rc);
      wait_not_busy();
      issue(ra, rb, rs, rc, e.r, e.cout, e.ovf);
      a = W'($urandom); b = W'($urandom); sub = ~rs; cin = ~rc;
    end
    drain();

    // start held high: second op only taken at FIN, first result unaffected
    begin
      exp_t e2;
      int k = 0;
      e2 = model(16'h0100, 16'h0023, 1'b0, 1'b0);
      a = 16'h1234; b = 16'h4321; sub = 0; cin = 0; start = 1'b1;
      q.push_back('{16'h5555, 1'b0, 1'b0, cyc + 1 + N});
      @(negedge clk);
      a = 16'h0100; b = 16'h0023;
      chk("hold_busy", 32'(busy), 1);
      while (busy && k < 100) begin @(negedge clk); k++; end
      chk("hold_run_len", 32'(k), N);
      e2.due = cyc + 1 + N;
      q.push_back(e2);
      @(negedge clk);
      start = 1'b0;
      drain();
    end

    // reset during RUN cycle 8: outputs clear at once, no done follows
    begin
      int d0;
      wait_not_busy();
      issue(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
      repeat (7) @(negedge clk);
      q.delete();
      d0 = n_done;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_r", 32'(r), 0);
      chk("mid_rst_cout", 32'(cout), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 4) @(negedge clk);
      chk("mid_rst_no_done", 32'(n_done - d0), 0);
    end

    // DIGIT=4: five cycles from accept to done
    begin
      int k = 0;
      a4 = 16'hABCD; b4 = 16'h1111; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      k = 1;
      while (!done4 && k < 50) begin @(negedge clk); k++; end
      chk("d4_latency", 32'(k), 5);
      chk("d4_r", 32'(r4), 32'h0000BCDE);
      chk("d4_cout", 32'(cout4), 0);
      chk("d4_ovf", 32'(ovf4), 0);
      @(negedge clk);
      chk("d4_done_pulse", 32'(done4), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
